// File: rtl/top_calc_pkg.sv
// Shared constants for the (A+B)*(C+D) pipeline: operand width and the
// derived result width, sized so the full product always fits.
package top_calc_pkg;

  localparam int unsigned CALC_DW = 8;
  localparam int unsigned CALC_SW = CALC_DW + 1;
  localparam int unsigned CALC_YW = 2 * CALC_SW;

endpackage

// File: rtl/mult_u.sv
// Stateless unsigned shift-and-add multiplier; the product is full width,
// so it never truncates.
module mult_u #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [2*W-1:0] a_ext;

  assign a_ext = {{W{1'b0}}, a};

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (b[i]) begin
        p = p + (a_ext << i);
      end
    end
  end

endmodule

// File: rtl/top_calc.sv
// Two-stage pipeline computing Y = (A+B)*(C+D): stage 1 registers the sums,
// stage 2 registers the product. One result per cycle, no back-pressure.
module top_calc
  import top_calc_pkg::*;
#(
  parameter  int unsigned DW = CALC_DW,
  localparam int unsigned YW = 2 * (DW + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          in_vld,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  input  logic [DW-1:0] D,
  output logic [YW-1:0] Y,
  output logic          out_vld
);

  localparam int unsigned SW = DW + 1;

  logic [SW-1:0] s0;
  logic [SW-1:0] s1;
  logic          s_vld;
  logic [YW-1:0] prod;

  mult_u #(.W(SW)) u_mult (
    .a (s0),
    .b (s1),
    .p (prod)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s0      <= '0;
      s1      <= '0;
      s_vld   <= 1'b0;
      Y       <= '0;
      out_vld <= 1'b0;
    end else begin
      s_vld   <= in_vld;
      out_vld <= s_vld;
      // Sums and product only move with their valid; otherwise they hold.
      if (in_vld) begin
        s0 <= {1'b0, A} + {1'b0, B};
        s1 <= {1'b0, C} + {1'b0, D};
      end
      if (s_vld) begin
        Y <= prod;
      end
    end
  end

endmodule

// File: tb/tb_top_calc.sv
// Scoreboard bench for top_calc: expected results are queued when an input
// set is accepted and compared when out_vld appears two cycles later.
module tb_top_calc;

  localparam int unsigned DW = 8;
  localparam int unsigned YW = 18;

  logic          sys_clk;
  logic          sys_rst;
  logic          in_vld;
  logic [DW-1:0] A, B, C, D;
  logic [YW-1:0] Y;
  logic          out_vld;

  int unsigned checks;
  int unsigned failures;

  int unsigned exp_q[$];
  logic [1:0]  v_pipe;
  int unsigned last_y;
  bit          started;

  top_calc #(.DW(DW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_vld  (in_vld),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .Y       (Y),
    .out_vld (out_vld)
  );

  initial sys_clk = 1'b0;
  always #50 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of what the DUT accepted at this edge.
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      exp_q.delete();
      v_pipe  = 2'b00;
      last_y  = 0;
      started = 1'b1;
    end else begin
      v_pipe = {v_pipe[0], in_vld};
      if (in_vld) begin
        exp_q.push_back((int'(A) + int'(B)) * (int'(C) + int'(D)));
      end
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      check("out_vld", 32'(out_vld), 32'(v_pipe[1]));
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          last_y = exp_q.pop_front();
          check("y_value", 32'(Y), last_y);
        end
      end else begin
        check("y_hold", 32'(Y), last_y);
      end
    end
  end

  task automatic drive(input logic v, input int unsigned a, input int unsigned b,
                       input int unsigned c, input int unsigned d);
    @(negedge sys_clk);
    in_vld = v;
    A = DW'(a);
    B = DW'(b);
    C = DW'(c);
    D = DW'(d);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    started  = 1'b0;
    v_pipe   = 2'b00;
    last_y   = 0;
    sys_rst  = 1'b1;
    in_vld   = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_y", 32'(Y), 0);
    check("reset_vld", 32'(out_vld), 0);
    sys_rst = 1'b0;

    drive(1'b1, 1, 2, 3, 4);          // 21
    idle(3);
    drive(1'b1, 255, 255, 255, 255);  // 260100
    idle(3);
    drive(1'b1, 0, 0, 0, 0);
    idle(2);
    drive(1'b1, 255, 0, 0, 0);
    idle(3);
    drive(1'b1, 1, 1, 1, 1);          // back-to-back: 4, 16, 2100
    drive(1'b1, 2, 2, 2, 2);
    drive(1'b1, 10, 20, 30, 40);
    idle(4);

    // Reset one cycle after a pulse discards it; Y returns to 0.
    drive(1'b1, 5, 6, 7, 8);
    @(negedge sys_clk);
    in_vld  = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("post_rst_y", 32'(Y), 0);
    idle(3);
    drive(1'b1, 3, 3, 3, 3);          // 36
    idle(3);

    // Reset coinciding with in_vld wins.
    @(negedge sys_clk);
    in_vld  = 1'b1;
    A = 8'd9; B = 8'd9; C = 8'd9; D = 8'd9;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    in_vld  = 1'b0;
    sys_rst = 1'b0;
    idle(3);
    check("rst_win_y", 32'(Y), 0);

    for (int i = 0; i < 200; i++) begin
      drive(1'b1, $urandom_range(255), $urandom_range(255),
            $urandom_range(255), $urandom_range(255));
    end
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom_range(1)), $urandom_range(255), $urandom_range(255),
            $urandom_range(255), $urandom_range(255));
    end
    idle(4);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top_calc.md
TOP_CALC -- requirements
Module: top_calc

Interface
REQ-001 Parameter: DW, default 8, width of each operand input.
REQ-002 Parameter: YW, default 2*(DW+1) = 18, width of result output; derived from DW, not independently overridable.
REQ-003 Port: sys_clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: sys_rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_vld  input  1  qualifies A, B, C, D in the current cycle.
REQ-006 Port: A  input  DW  unsigned operand.
REQ-007 Port: B  input  DW  unsigned operand.
REQ-008 Port: C  input  DW  unsigned operand.
REQ-009 Port: D  input  DW  unsigned operand.
REQ-010 Port: Y  output  YW  registered result (A+B)*(C+D).
REQ-011 Port: out_vld  output  1  high for exactly one cycle per accepted input set, aligned with Y.

Function
REQ-012 Y SHALL equal (A+B)*(C+D) for the operand set sampled when in_vld=1, all arithmetic unsigned.
REQ-013 Stage 1 SHALL register S0=A+B and S1=C+D, each DW+1 bits, no truncation.
REQ-014 Stage 2 SHALL register Y=S0*S1 at full YW width; no overflow is possible (max 510*510=260100 < 2^18).
REQ-015 Latency SHALL be exactly 2 cycles: in_vld sampled at edge N gives Y/out_vld valid after edge N+2.
REQ-016 The pipeline SHALL accept one new operand set every cycle with no stalls; throughput 1 result/cycle.
REQ-017 No back-pressure; out_vld carries no handshake and results are never held or dropped.
REQ-018 When in_vld=0, stage-1 valid SHALL clear and the operand registers hold their previous values.
REQ-019 When out_vld=0, Y SHALL hold its last valid value.
REQ-020 Inputs SHALL be sampled only at the rising edge; no combinational path from inputs to Y or out_vld.

Reset
REQ-021 While sys_rst=1 at a rising edge, Y, out_vld, S0, S1 and all internal valid bits SHALL become 0.
REQ-022 Reset mid-operation SHALL discard all in-flight operand sets; out_vld stays 0 until 2 cycles after the first in_vld=1 sampled with sys_rst=0.
REQ-023 If sys_rst and in_vld are both 1 at the same edge, reset SHALL win and the operand set is discarded.

Structure
REQ-024 DW and derived YW SHALL be defined as constants in a shared package, top_calc_pkg.
REQ-025 The multiply SHALL be a combinational sub-module, mult_u, with parameterised operand width, unsigned shift-and-add array form, no vendor primitives.
REQ-026 The adders and pipeline registers SHALL reside in top_calc; mult_u SHALL contain no state.

Verification
REQ-027 Test: A=1,B=2,C=3,D=4, in_vld pulse -> after 2 cycles Y=21, out_vld=1 for one cycle.
REQ-028 Test: A=B=C=D=255 -> Y=260100 (0x3F804), no truncation.
REQ-029 Test: A=B=C=D=0 -> Y=0 with out_vld=1; and A=255,B=0,C=0,D=0 -> Y=0.
REQ-030 Test: back-to-back in_vld for 3 cycles with (1,1,1,1), (2,2,2,2), (10,20,30,40) -> consecutive Y=4, 16, 2100 with out_vld high 3 cycles.
REQ-031 Test: sys_rst asserted 1 cycle after an in_vld pulse -> no out_vld, Y=0; next clean input set gives correct Y at 2-cycle latency.
REQ-032 Test: random operands (0..255) every 100 ns with in_vld=1, checked against the reference model (A+B)*(C+D).
